snow64_direct_mapped_instr_cache: RTL and testbench

Parametrised successor to the single-line fake instruction cache. It is a direct-mapped, read-only instruction cache with NUM_LINES lines, and it sits between instruction fetch and the memory arbiter. It adds:
- multiple lines with tag compare
- line-aligned fill addresses
- whole-cache invalidate
- a saturating miss counter

Addresses are instruction-word indices: the low offset bits select the instruction within a line.

---
 rtl/snow64_direct_mapped_instr_cache.sv | 175 +++++++++++++++++
 tb/tb_snow64_direct_mapped_instr_cache.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snow64_direct_mapped_instr_cache.sv
`default_nettype none
// ============================================================================
// Module   : snow64_direct_mapped_instr_cache
// Brief    : Direct-mapped read-only instruction cache with line fill,
//            whole-cache invalidate and a saturating miss counter.
// Revision : 1.0 - initial release
// ============================================================================
module snow64_direct_mapped_instr_cache #(
    parameter int ADDR_WIDTH     = 64,
    parameter int INSTR_WIDTH    = 32,
    parameter int LINE_WIDTH     = 256,
    parameter int NUM_LINES      = 8,
    parameter int MISS_CNT_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_req_read_req,
    input  logic [ADDR_WIDTH-1:0]     in_req_read_addr,
    input  logic                      in_invalidate,
    output logic                      out_req_read_valid,
    output logic [INSTR_WIDTH-1:0]    out_req_read_instr,
    output logic                      out_mem_access_req,
    output logic [ADDR_WIDTH-1:0]     out_mem_access_addr,
    input  logic                      in_mem_access_valid,
    input  logic [LINE_WIDTH-1:0]     in_mem_access_data,
    output logic [MISS_CNT_WIDTH-1:0] out_miss_count
);

    localparam int c_WORDS = LINE_WIDTH / INSTR_WIDTH;
    localparam int c_OFF_W = $clog2(c_WORDS);
    localparam int c_IDX_W = $clog2(NUM_LINES);
    localparam int c_TAG_W = ADDR_WIDTH - c_OFF_W - c_IDX_W;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_WAIT_MEM = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [NUM_LINES-1:0]      r_valid;
    logic [c_TAG_W-1:0]        r_tag  [NUM_LINES];
    logic [LINE_WIDTH-1:0]     r_data [NUM_LINES];
    logic [c_TAG_W-1:0]        r_ctag;
    logic [c_IDX_W-1:0]        r_cidx;
    logic [c_OFF_W-1:0]        r_coff;
    logic                      r_inv_pending;
    logic                      r_rd_valid;
    logic [INSTR_WIDTH-1:0]    r_rd_instr;
    logic                      r_mem_req;
    logic [ADDR_WIDTH-1:0]     r_mem_addr;
    logic [MISS_CNT_WIDTH-1:0] r_miss_count;

    logic [c_TAG_W-1:0]     w_tag;
    logic [c_IDX_W-1:0]     w_idx;
    logic [c_OFF_W-1:0]     w_off;
    logic                   w_hit;
    logic                   w_fill;
    logic [INSTR_WIDTH-1:0] w_hit_word;
    logic [INSTR_WIDTH-1:0] w_fill_word;

    function automatic logic [INSTR_WIDTH-1:0] f_word(
        input logic [LINE_WIDTH-1:0] line,
        input logic [c_OFF_W-1:0]    off
    );
        f_word = '0;
        for (int k = 0; k < c_WORDS; k++) begin
            if (off == c_OFF_W'(k)) begin
                f_word = line[k*INSTR_WIDTH +: INSTR_WIDTH];
            end
        end
    endfunction

    assign w_tag       = in_req_read_addr[ADDR_WIDTH-1 -: c_TAG_W];
    assign w_idx       = in_req_read_addr[c_OFF_W +: c_IDX_W];
    assign w_off       = in_req_read_addr[c_OFF_W-1:0];
    assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_hit_word  = f_word(r_data[w_idx], w_off);
    assign w_fill_word = f_word(in_mem_access_data, r_coff);
    assign w_fill      = (r_state == ST_WAIT_MEM) && in_mem_access_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!in_invalidate && in_req_read_req && !w_hit) begin
                    w_state_next = ST_WAIT_MEM;
                end
            end
            ST_WAIT_MEM: begin
                if (in_mem_access_valid) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid       <= '0;
            r_ctag        <= '0;
            r_cidx        <= '0;
            r_coff        <= '0;
            r_inv_pending <= 1'b0;
            r_rd_valid    <= 1'b0;
            r_rd_instr    <= '0;
            r_mem_req     <= 1'b0;
            r_mem_addr    <= '0;
            r_miss_count  <= '0;
        end else begin
            r_rd_valid <= 1'b0;
            r_mem_req  <= 1'b0;
            if (r_state == ST_IDLE) begin
                if (in_invalidate) begin
                    r_valid <= '0;
                end else if (in_req_read_req) begin
                    if (w_hit) begin
                        r_rd_valid <= 1'b1;
                        r_rd_instr <= w_hit_word;
                    end else begin
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= {in_req_read_addr[ADDR_WIDTH-1:c_OFF_W], {c_OFF_W{1'b0}}};
                        r_ctag     <= w_tag;
                        r_cidx     <= w_idx;
                        r_coff     <= w_off;
                        if (!(&r_miss_count)) begin
                            r_miss_count <= r_miss_count + MISS_CNT_WIDTH'(1);
                        end
                    end
                end
            end else begin
                if (in_invalidate) begin
                    r_inv_pending <= 1'b1;
                end
                if (in_mem_access_valid) begin
                    // An invalidate seen at any point during the fill also kills the new line.
                    if (r_inv_pending || in_invalidate) begin
                        r_valid <= '0;
                    end else begin
                        r_valid[r_cidx] <= 1'b1;
                    end
                    r_rd_valid    <= 1'b1;
                    r_rd_instr    <= w_fill_word;
                    r_inv_pending <= 1'b0;
                end
            end
        end
    end

    // Tag and data storage carry no reset; the valid bits gate their use.
    always_ff @(posedge clk) begin
        if (!rst && w_fill) begin
            r_tag[r_cidx]  <= r_ctag;
            r_data[r_cidx] <= in_mem_access_data;
        end
    end

    assign out_req_read_valid  = r_rd_valid;
    assign out_req_read_instr  = r_rd_instr;
    assign out_mem_access_req  = r_mem_req;
    assign out_mem_access_addr = r_mem_addr;
    assign out_miss_count      = r_miss_count;

endmodule
`default_nettype wire

// File: tb/tb_snow64_direct_mapped_instr_cache.sv
`default_nettype none
// ============================================================================
// Module   : tb_snow64_direct_mapped_instr_cache
// Brief    : Randomised and directed bench with a line-level cache model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_snow64_direct_mapped_instr_cache;

    localparam int NL = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req = 1'b0;
    logic [63:0]  addr = '0;
    logic         inval = 1'b0;
    logic         mem_valid = 1'b0;
    logic [255:0] mem_data = '0;

    logic         rd_valid, mem_req, s_rd_valid, s_mem_req;
    logic [31:0]  rd_instr, s_rd_instr, miss_cnt;
    logic [63:0]  mem_addr, s_mem_addr;
    logic [1:0]   s_miss_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    snow64_direct_mapped_instr_cache dut (
        .clk(clk), .rst(rst),
        .in_req_read_req(req), .in_req_read_addr(addr), .in_invalidate(inval),
        .out_req_read_valid(rd_valid), .out_req_read_instr(rd_instr),
        .out_mem_access_req(mem_req), .out_mem_access_addr(mem_addr),
        .in_mem_access_valid(mem_valid), .in_mem_access_data(mem_data),
        .out_miss_count(miss_cnt)
    );

    snow64_direct_mapped_instr_cache #(.MISS_CNT_WIDTH(2)) dut_sat (
        .clk(clk), .rst(rst),
        .in_req_read_req(req), .in_req_read_addr(addr), .in_invalidate(inval),
        .out_req_read_valid(s_rd_valid), .out_req_read_instr(s_rd_instr),
        .out_mem_access_req(s_mem_req), .out_mem_access_addr(s_mem_addr),
        .in_mem_access_valid(mem_valid), .in_mem_access_data(mem_data),
        .out_miss_count(s_miss_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [255:0] gen_line(input logic [63:0] a);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[k*32 +: 32] = 32'hA000_0000 + a[31:0] - 32'h10 + 32'(k);
        return l;
    endfunction

    // ---------------- line-level reference model ----------------
    bit           m_known = 1'b0;
    bit           m_valid [NL];
    logic [63:0]  m_lineno [NL];
    logic [255:0] m_data [NL];
    bit           m_busy = 1'b0, m_pinv = 1'b0;
    logic [63:0]  m_paddr = '0;
    longint       m_misses = 0;
    bit           e_valid, e_mreq, e_rst;
    logic [31:0]  e_instr;
    logic [63:0]  e_maddr, ln;
    int           ix;

    always @(posedge clk) begin
        e_valid = 1'b0; e_mreq = 1'b0; e_rst = 1'b0;
        if (rst) begin
            m_known = 1'b1; e_rst = 1'b1;
            foreach (m_valid[i]) m_valid[i] = 1'b0;
            m_busy = 1'b0; m_pinv = 1'b0; m_misses = 0;
        end else if (!m_busy) begin
            if (inval) begin
                foreach (m_valid[i]) m_valid[i] = 1'b0;
            end else if (req) begin
                ln = addr >> 3;
                ix = int'(ln % 64'(NL));
                if (m_valid[ix] && m_lineno[ix] == ln) begin
                    e_valid = 1'b1;
                    e_instr = m_data[ix][int'(addr[2:0])*32 +: 32];
                end else begin
                    m_busy = 1'b1; m_paddr = addr; m_misses++;
                    e_mreq = 1'b1; e_maddr = ln << 3;
                end
            end
        end else begin
            if (inval) m_pinv = 1'b1;
            if (mem_valid) begin
                ln = m_paddr >> 3;
                ix = int'(ln % 64'(NL));
                m_data[ix] = mem_data; m_lineno[ix] = ln;
                if (m_pinv) begin
                    foreach (m_valid[i]) m_valid[i] = 1'b0;
                end else begin
                    m_valid[ix] = 1'b1;
                end
                e_valid = 1'b1;
                e_instr = mem_data[int'(m_paddr[2:0])*32 +: 32];
                m_busy = 1'b0; m_pinv = 1'b0;
            end
        end
        #1;
        if (m_known) begin
            chk("rd_valid", rd_valid, e_valid);
            chk("mem_req", mem_req, e_mreq);
            chk("miss_count", miss_cnt, m_misses[31:0]);
            chk("sat_rd_valid", s_rd_valid, e_valid);
            chk("sat_mem_req", s_mem_req, e_mreq);
            chk("sat_miss_count", s_miss_cnt, (m_misses > 3) ? 64'd3 : 64'(m_misses));
            if (e_valid) begin
                chk("rd_instr", rd_instr, e_instr);
                chk("sat_rd_instr", s_rd_instr, e_instr);
            end
            if (e_mreq) begin
                chk("mem_addr", mem_addr, e_maddr);
                chk("sat_mem_addr", s_mem_addr, e_maddr);
            end
            if (e_rst) begin
                chk("rst_instr", rd_instr, 64'd0);
                chk("rst_mem_addr", mem_addr, 64'd0);
            end
        end
    end

    // ---------------- memory responder ----------------
    bit          mem_auto = 1'b1;
    int          mem_lat = 1;
    int          fire_cnt = 0;
    logic [63:0] fire_addr = '0;
    int          manual_req = 0, manual_done = 0;
    logic [63:0] manual_addr = '0;

    always @(negedge clk) begin
        mem_valid = 1'b0;
        if (manual_req != manual_done) begin
            manual_done = manual_req;
            mem_valid = 1'b1; mem_data = gen_line(manual_addr);
        end else if (fire_cnt > 0) begin
            fire_cnt--;
            if (fire_cnt == 0) begin
                mem_valid = 1'b1; mem_data = gen_line(fire_addr);
            end
        end
        if (mem_auto && mem_req === 1'b1) begin
            fire_cnt = mem_lat; fire_addr = mem_addr;
        end
    end

    // ---------------- requester ----------------
    logic [31:0] f_instr;
    int          f_cyc, f_nreq;
    logic [63:0] f_maddr;

    task automatic fetch(input logic [63:0] a);
        @(negedge clk);
        req = 1'b1; addr = a; f_cyc = 0; f_nreq = 0; f_maddr = '0;
        while (1) begin
            @(posedge clk); #1;
            f_cyc++;
            if (mem_req) begin f_nreq++; f_maddr = mem_addr; end
            if (rd_valid) break;
            if (f_cyc >= 60) begin chk("fetch_timeout", 64'(f_cyc), 64'd0); break; end
        end
        f_instr = rd_instr;
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1; req = 1'b0; inval = 1'b0;
        @(negedge clk); rst = 1'b0;
    endtask

    initial begin
        logic [63:0] ra;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_valid", rd_valid, 64'd0);
        chk("reset_mem_req", mem_req, 64'd0);
        chk("reset_miss", miss_cnt, 64'd0);
        chk("reset_instr", rd_instr, 64'd0);

        // cold miss then hit
        fetch(64'h13);
        chk("t1_nreq", 64'(f_nreq), 64'd1);
        chk("t1_maddr", f_maddr, 64'h10);
        chk("t1_instr", f_instr, 64'hA000_0003);
        fetch(64'h17);
        chk("t1_hit_cyc", 64'(f_cyc), 64'd1);
        chk("t1_hit_nreq", 64'(f_nreq), 64'd0);
        chk("t1_hit_instr", f_instr, 64'hA000_0007);

        // conflict eviction on index 2
        fetch(64'h50);
        chk("t2_nreq", 64'(f_nreq), 64'd1);
        chk("t2_maddr", f_maddr, 64'h50);
        fetch(64'h10);
        chk("t2_refill_nreq", 64'(f_nreq), 64'd1);
        chk("t2_miss", miss_cnt, 64'd3);

        // distinct indices, back-to-back hits
        do_reset();
        fetch(64'h00);
        fetch(64'h08);
        for (int i = 0; i < 6; i++) begin
            fetch((i % 2 == 0) ? 64'h01 : 64'h09);
            chk("t3_cyc", 64'(f_cyc), 64'd1);
            chk("t3_instr", f_instr, (i % 2 == 0) ? 64'h9FFF_FFF1 : 64'h9FFF_FFF9);
        end
        chk("t3_miss", miss_cnt, 64'd2);

        // invalidate in IDLE and during WAIT_MEM
        do_reset();
        fetch(64'h20);
        @(negedge clk); req = 1'b0; inval = 1'b1;
        @(negedge clk); inval = 1'b0;
        fetch(64'h20);
        chk("t4_idle_inval_nreq", 64'(f_nreq), 64'd1);
        mem_lat = 3;
        fork
            fetch(64'h28);
            begin
                repeat (2) @(negedge clk);
                inval = 1'b1;
                @(negedge clk);
                inval = 1'b0;
            end
        join
        chk("t4_wait_inval_instr", f_instr, 64'hA000_0018);
        mem_lat = 1;
        fetch(64'h28);
        chk("t4_wait_inval_nreq", 64'(f_nreq), 64'd1);

        // reset mid-fill, then stray fill data in IDLE
        do_reset();
        mem_auto = 1'b0;
        @(negedge clk); req = 1'b1; addr = 64'h30;
        @(posedge clk); #1;
        chk("t5_mem_req", mem_req, 64'd1);
        @(negedge clk); req = 1'b0; rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("t5_valid", rd_valid, 64'd0);
        chk("t5_mem_req_after", mem_req, 64'd0);
        chk("t5_miss", miss_cnt, 64'd0);
        manual_addr = 64'h30; manual_req++;
        repeat (3) begin
            @(posedge clk); #1;
            chk("t5_stray_valid", rd_valid, 64'd0);
        end
        mem_auto = 1'b1;
        fetch(64'h30);
        chk("t5_refetch_nreq", 64'(f_nreq), 64'd1);

        // saturation on the 2-bit counter instance
        do_reset();
        for (int i = 0; i < 5; i++) fetch(64'(i) << 6);
        chk("t6_sat", s_miss_cnt, 64'd3);
        chk("t6_full", miss_cnt, 64'd5);

        // randomised traffic
        for (int n = 0; n < 400; n++) begin
            mem_lat = $urandom_range(1, 4);
            ra = {(($urandom % 2) != 0) ? 32'hDEAD_0000 : 32'h0, 23'd0, 9'($urandom)};
            if ($urandom % 8 == 0) begin
                fork
                    fetch(ra);
                    begin
                        repeat ($urandom_range(1, 4)) @(negedge clk);
                        inval = 1'b1;
                        @(negedge clk);
                        inval = 1'b0;
                    end
                join
            end else begin
                fetch(ra);
            end
            if ($urandom % 6 == 0) begin
                @(negedge clk); req = 1'b0;
            end
        end
        @(negedge clk); req = 1'b0;
        repeat (8) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
